// File: rtl/pwm_sine_sequencer_pkg.sv
// Shared types and helpers for the PWM sine sequencer and its frame timer.
package pwm_sine_sequencer_pkg;

    // Sequencer states: idle, two ROM priming cycles, free running, and draining the last frame.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME1 = 3'd1,
        PRIME2 = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    // Width of the in-frame cycle counter for a given frame length (CNT_W = $clog2(PERIOD)).
    function automatic int cnt_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

    // Saturate a ROM sample at the frame length; anything at or above it means "high all frame".
    function automatic logic [31:0] clamp(input logic [31:0] x, input logic [31:0] limit);
        return (x > limit) ? limit : x;
    endfunction

endpackage

// File: rtl/pwm_sine_sequencer_frame_timer.sv
// Frame timer: counts cycles within a PWM frame while running and flags the final cycle.
module pwm_sine_sequencer_frame_timer
    import pwm_sine_sequencer_pkg::*;
#(
    parameter  int PERIOD = 1000,
    localparam int CNT_W  = cnt_width(PERIOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..PERIOD-1 and wrap while running; hold at zero otherwise so a new run starts a fresh frame.
    always_comb begin
        cnt_d = '0;
        if (run && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pwm_sine_sequencer.sv
// PWM sine sequencer: steps a phase accumulator once per frame, fetches the next duty
// from an external 1-cycle-latency sine ROM, double-buffers it to frame boundaries and
// drives a registered PWM compare. Also owns start/stop/drain and step configuration.
module pwm_sine_sequencer
    import pwm_sine_sequencer_pkg::*;
#(
    parameter int            PERIOD       = 1000,
    parameter int            DW           = 16,
    parameter int            AW           = 8,
    parameter int            PW           = 24,
    parameter logic [PW-1:0] STEP_DEFAULT = PW'(1) << (PW - AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] cfg_step,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          pwm_out,
    output logic          frame_tick,
    output logic          busy,
    output logic [DW-1:0] duty
);

    localparam int               CNT_W        = cnt_width(PERIOD);
    localparam logic [CNT_W-1:0] CNT_FETCH    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_SHADOW   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(PERIOD - 2);

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] step_q, step_d;
    logic [PW-1:0] staged_q, staged_d;
    logic          pending_q, pending_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          rom_en_q, rom_en_d;
    logic          pwm_q, pwm_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;

    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             timer_run;
    logic             fetch_cycle;
    logic             shadow_cycle;
    logic             boundary;
    logic             idle_entry;
    logic             cfg_xfer;
    logic             cfg_apply;
    logic [PW-1:0]    phase_next;
    logic [DW-1:0]    rom_clamped;

    // The frame only advances while generating with the PLL locked; losing lock zeroes it next cycle.
    assign timer_run = en && ((state_q == RUN) || (state_q == DRAIN));

    pwm_sine_sequencer_frame_timer #(
        .PERIOD(PERIOD)
    ) u_frame_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (timer_run),
        .cnt  (cnt),
        .last (last)
    );

    assign fetch_cycle  = en && (state_q == RUN) && (cnt == CNT_FETCH);
    assign shadow_cycle = en && (state_q == RUN) && (cnt == CNT_SHADOW);
    assign boundary     = (state_q == RUN) && last;
    assign phase_next   = phase_q + step_q;
    assign rom_clamped  = DW'(clamp(32'(rom_data), 32'(PERIOD)));

    // Sequencing: lock loss wins over everything, stop during priming aborts, stop while running drains.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d = PRIME1;
                    end
                end
                PRIME1: begin
                    state_d = stop ? IDLE : PRIME2;
                end
                PRIME2: begin
                    state_d = stop ? IDLE : RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_d = last ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Phase stepping, ROM addressing and the double-buffered duty (shadow loads mid-frame, duty at the boundary).
    always_comb begin
        phase_d    = phase_q;
        rom_addr_d = rom_addr_q;
        duty_d     = duty_q;
        shadow_d   = shadow_q;
        if ((state_q == IDLE) && (state_d == PRIME1)) begin
            phase_d    = '0;
            rom_addr_d = '0;
        end
        if (fetch_cycle) begin
            phase_d    = phase_next;
            rom_addr_d = phase_next[PW-1 -: AW];
        end
        if ((state_q == PRIME2) && (state_d == RUN)) begin
            duty_d   = rom_clamped;
            shadow_d = rom_clamped;
        end
        if (shadow_cycle) begin
            shadow_d = rom_clamped;
        end
        if (boundary) begin
            duty_d = shadow_q;
        end
    end

    // Step configuration: direct write when idle, otherwise staged until a frame boundary or a clean return to idle.
    always_comb begin
        step_d     = step_q;
        staged_d   = staged_q;
        pending_d  = pending_q;
        idle_entry = en && (state_q != IDLE) && (state_d == IDLE);
        cfg_xfer   = cfg_valid && !pending_q;
        cfg_apply  = pending_q && (boundary || idle_entry);
        if (cfg_apply) begin
            step_d    = staged_q;
            pending_d = 1'b0;
        end
        if (cfg_xfer) begin
            if (state_q == IDLE) begin
                step_d = cfg_step;
            end else begin
                staged_d  = cfg_step;
                pending_d = 1'b1;
            end
        end
    end

    // Registered output decode, computed from the upcoming state so every output lines up with it.
    always_comb begin
        busy_d   = (state_d != IDLE);
        rom_en_d = (state_d == PRIME1) || (fetch_cycle && (state_d == RUN));
        tick_d   = timer_run && (cnt == CNT_PRE_LAST);
        pwm_d    = timer_run && (32'(cnt) < 32'(duty_q));
    end

    // Single register bank for the FSM, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            step_q     <= STEP_DEFAULT;
            staged_q   <= '0;
            pending_q  <= 1'b0;
            duty_q     <= '0;
            shadow_q   <= '0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            pwm_q      <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            staged_q   <= staged_d;
            pending_q  <= pending_d;
            duty_q     <= duty_d;
            shadow_q   <= shadow_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            pwm_q      <= pwm_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
        end
    end

    assign cfg_ready  = !pending_q;
    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign pwm_out    = pwm_q;
    assign frame_tick = tick_q;
    assign busy       = busy_q;
    assign duty       = duty_q;

endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// Testbench for pwm_sine_sequencer: directed stimulus pushes expected ROM reads and
// per-frame results into queues; an independent monitor pops and compares them.
module tb_pwm_sine_sequencer;

    localparam int PERIOD = 8;
    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int PW     = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] cfg_step = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          pwm_out;
    logic          frame_tick;
    logic          busy;
    logic [DW-1:0] duty;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int duty;
        int highs;
    } frame_exp_t;

    frame_exp_t frame_q[$];
    int         addr_q[$];

    pwm_sine_sequencer #(
        .PERIOD(PERIOD),
        .DW    (DW),
        .AW    (AW),
        .PW    (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .stop      (stop),
        .cfg_step  (cfg_step),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pwm_out   (pwm_out),
        .frame_tick(frame_tick),
        .busy      (busy),
        .duty      (duty)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Sine ROM stand-in: data equals address, except address 3 returns an out-of-range value.
    function automatic logic [DW-1:0] rom_model(input logic [AW-1:0] a);
        if (a == 4'd3) begin
            return 8'd200;
        end
        return {4'b0000, a};
    endfunction

    // ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data <= rom_model(rom_addr);
        end
    end

    // Compare one value and report a failure line on mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance n cycles, leaving the bench at 1 time unit past the rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one cycle of inputs; single-cycle pulses are dropped afterwards while en is held.
    task automatic applyStimulus(input logic s_en, input logic s_start, input logic s_stop,
                                 input logic s_cfg_valid, input logic [PW-1:0] s_cfg_step);
        en        = s_en;
        start     = s_start;
        stop      = s_stop;
        cfg_valid = s_cfg_valid;
        cfg_step  = s_cfg_step;
        wait_cycles(1);
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic push_frame(input int d, input int h);
        frame_q.push_back('{d, h});
    endtask

    task automatic check_reset_values();
        checkOutput("rst_pwm_out", int'(pwm_out), 0);
        checkOutput("rst_frame_tick", int'(frame_tick), 0);
        checkOutput("rst_rom_en", int'(rom_en), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_cfg_ready", int'(cfg_ready), 1);
        checkOutput("rst_duty", int'(duty), 0);
        checkOutput("rst_rom_addr", int'(rom_addr), 0);
    endtask

    task automatic check_prime();
        checkOutput("prime_busy", int'(busy), 1);
        checkOutput("prime_rom_en", int'(rom_en), 1);
        checkOutput("prime_rom_addr", int'(rom_addr), 0);
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_pwm_out"}, int'(pwm_out), 0);
        checkOutput({tag, "_rom_en"}, int'(rom_en), 0);
    endtask

    // Monitor state: PWM highs are counted one cycle late because pwm_out is registered.
    int         hi_cnt = 0;
    logic       tick_prev = 1'b0;
    int         tick_duty = 0;
    int         exp_addr;
    frame_exp_t exp_frame;

    // Monitor: every ROM read and every completed frame is popped from its queue and compared.
    always @(negedge clk) begin
        if (rom_en === 1'b1) begin
            if (addr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL rom_read_unexpected: got addr %0d, expected no read", rom_addr);
            end else begin
                exp_addr = addr_q.pop_front();
                checkOutput("rom_addr", int'(rom_addr), exp_addr);
            end
        end
        if (busy !== 1'b1 && !tick_prev) begin
            hi_cnt = 0;
        end else begin
            hi_cnt = hi_cnt + int'(pwm_out);
        end
        if (tick_prev) begin
            if (frame_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL frame_unexpected: got duty %0d highs %0d, expected no frame",
                         tick_duty, hi_cnt);
            end else begin
                exp_frame = frame_q.pop_front();
                checkOutput("frame_duty", tick_duty, exp_frame.duty);
                checkOutput("frame_highs", hi_cnt, exp_frame.highs);
            end
            hi_cnt = 0;
        end
        tick_prev = (frame_tick === 1'b1);
        if (frame_tick === 1'b1) begin
            tick_duty = int'(duty);
        end
    end

    // Directed scenarios; cycle offsets are relative to the cycle T in which start is driven.
    initial begin
        @(posedge clk);
        #1;

        // Reset state, then start with default step: frame k has duty k, addr 3 clamps to 8.
        rst_n = 1'b0;
        wait_cycles(2);
        check_reset_values();
        rst_n = 1'b1;
        en    = 1'b1;
        wait_cycles(1);
        for (int a = 0; a <= 6; a++) begin
            addr_q.push_back(a);
        end
        push_frame(0, 0);
        push_frame(1, 1);
        push_frame(2, 2);
        push_frame(8, 8);
        push_frame(4, 4);
        push_frame(5, 5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_prime();
        wait_cycles(44);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
        wait_cycles(5);
        check_idle("after_drain");
        checkOutput("after_drain_tick", int'(frame_tick), 0);
        wait_cycles(4);

        // Step change to 32 during frame 1, a rejected second request, then a one-cycle lock loss.
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        addr_q.push_back(0);
        addr_q.push_back(1);
        addr_q.push_back(2);
        addr_q.push_back(4);
        addr_q.push_back(6);
        addr_q.push_back(8);
        push_frame(0, 0);
        push_frame(1, 1);
        push_frame(2, 2);
        push_frame(4, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        wait_cycles(12);
        checkOutput("cfg_ready_before", int'(cfg_ready), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd32);
        checkOutput("cfg_ready_pending", int'(cfg_ready), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd64);
        checkOutput("cfg_ready_still_pending", int'(cfg_ready), 0);
        wait_cycles(4);
        checkOutput("cfg_ready_after_boundary", int'(cfg_ready), 1);
        wait_cycles(20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_idle("lock_loss");

        // Restart keeps step 32, then reset mid-frame restores step 16.
        addr_q.push_back(0);
        addr_q.push_back(2);
        addr_q.push_back(4);
        addr_q.push_back(6);
        push_frame(0, 0);
        push_frame(2, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_prime();
        wait_cycles(23);
        rst_n = 1'b0;
        wait_cycles(1);
        check_reset_values();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check_idle("start_stop");
        addr_q.push_back(0);
        addr_q.push_back(1);
        addr_q.push_back(2);
        push_frame(0, 0);
        push_frame(1, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check_prime();
        wait_cycles(12);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
        wait_cycles(5);
        check_idle("final_drain");
        wait_cycles(4);

        checkOutput("rom_reads_missing", addr_q.size(), 0);
        checkOutput("frames_missing", frame_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
